// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the up/down decade counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // 0.671 s step period at a 50 MHz clock
  localparam int unsigned TICK_DIV_DEFAULT = 33554432;

  function automatic bcd_digit_t bcd_clamp(input logic [3:0] val);
    return (val > BCD_MAX) ? BCD_MAX : val;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Shared BCD to active-low 7-segment decoder, seg[0]=a .. seg[6]=g.
// Only compiled into builds that define BCD_UPDOWN_HEX_EN.
`ifdef BCD_UPDOWN_HEX_EN
module bcd7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule
`endif

// File: rtl/bcd_digit.sv
// One BCD decade cell: loadable, steps up or down when its carry/borrow input is set.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up_dn,
  input  logic       cin,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] digit,
  output logic       cout
);

  // cin doubles as borrow-in when counting down
  assign cout = cin & (up_dn ? (digit == BCD_MAX) : (digit == BCD_MIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(ld_val);
    end else if (step && cin) begin
      if (up_dn) begin
        digit <= (digit >= BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Prescaled multi-decade BCD up/down counter with load, tick/wrap pulses and 7-seg outputs.
// Define BCD_UPDOWN_HEX_EN to build the per-digit decoders; otherwise hex is blank (all ones).
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY0,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_tc;
  logic          step;
  logic [DIGITS:0] carry;

  assign presc_tc = (presc == PW'(TICK_DIV - 1));
  // load wins over a coincident step
  assign step     = en & presc_tc & ~load;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc_tc ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= step & carry[DIGITS];
    end
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk    (CLOCK_50),
      .rst_n  (KEY0),
      .step   (step),
      .up_dn  (up_dn),
      .cin    (carry[g]),
      .load   (load),
      .ld_val (load_val[4*g +: 4]),
      .digit  (bcd[4*g +: 4]),
      .cout   (carry[g+1])
    );
  end

`ifdef BCD_UPDOWN_HEX_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_hex
    bcd7seg u_seg (
      .digit (bcd[4*g +: 4]),
      .seg   (hex[7*g +: 7])
    );
  end
`else
  assign hex = '1;
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter with DIGITS=3, TICK_DIV=4; expectations hand-computed.
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up_dn;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] bcd;
  logic        tick;
  logic        wrap;
  logic [20:0] hex;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bcd_updown_counter #(.DIGITS(3), .TICK_DIV(4)) dut (
    .CLOCK_50 (clk),
    .KEY0     (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .tick     (tick),
    .wrap     (wrap),
    .hex      (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7f;
    endcase
  endfunction

  function automatic logic [20:0] hex_exp(input logic [11:0] v);
`ifdef BCD_UPDOWN_HEX_EN
    return {seg_of(v[11:8]), seg_of(v[7:4]), seg_of(v[3:0])};
`else
    return '1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_state(input string tag, input logic [11:0] b, input logic t, input logic w);
    chk({tag, "_bcd"}, 32'(bcd), 32'(b));
    chk({tag, "_tick"}, 32'(tick), 32'(t));
    chk({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  task automatic do_load(input logic [11:0] v);
    load_val = v;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    #3;
    chk_state("reset", 12'h000, 1'b0, 1'b0);
    chk("reset_hex", 32'(hex), 32'(hex_exp(12'h000)));

    // 40 enabled up cycles: step on every 4th edge
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      chk("count_tick", 32'(tick), 32'((k % 4) == 0));
      chk("count_wrap", 32'(wrap), 32'(0));
    end
    chk("count_bcd", 32'(bcd), 32'h010);

    // Up rollover 998 -> 999 -> 000
    do_load(12'h998);
    chk_state("ld998", 12'h998, 1'b0, 1'b0);
    cyc(3);
    chk_state("pre999", 12'h998, 1'b0, 1'b0);
    cyc(1);
    chk_state("up999", 12'h999, 1'b1, 1'b0);
    cyc(4);
    chk_state("up000", 12'h000, 1'b1, 1'b1);
    chk("up000_hex", 32'(hex), 32'(hex_exp(12'h000)));
    cyc(1);
    chk_state("after_wrap", 12'h000, 1'b0, 1'b0);

    // Down underflow 000 -> 999 -> 998
    up_dn = 1'b0;
    do_load(12'h000);
    cyc(4);
    chk_state("dn999", 12'h999, 1'b1, 1'b1);
    cyc(4);
    chk_state("dn998", 12'h998, 1'b1, 1'b0);

    // Direction change produces no pulse; load in step cycle wins
    up_dn = 1'b1;
    cyc(1);
    chk_state("dir_chg", 12'h998, 1'b0, 1'b0);
    cyc(2);
    do_load(12'h3A5);
    chk_state("ld3a5", 12'h395, 1'b0, 1'b0);
    chk("ld3a5_hex", 32'(hex), 32'(hex_exp(12'h395)));
    cyc(3);
    chk_state("pre396", 12'h395, 1'b0, 1'b0);
    cyc(1);
    chk_state("up396", 12'h396, 1'b1, 1'b0);

    // Hold with en=0 at prescaler=2
    cyc(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("hold_tick", 32'(tick), 32'(0));
      chk("hold_bcd", 32'(bcd), 32'h396);
    end
    en = 1'b1;
    cyc(1);
    chk_state("reen1", 12'h396, 1'b0, 1'b0);
    cyc(1);
    chk_state("reen2", 12'h397, 1'b1, 1'b0);

    // Digit clamp, load while disabled, multi-digit borrow
    do_load(12'hFAB);
    chk("clamp_bcd", 32'(bcd), 32'h999);
    en = 1'b0;
    do_load(12'h100);
    chk_state("ld_dis", 12'h100, 1'b0, 1'b0);
    en = 1'b1; up_dn = 1'b0;
    cyc(4);
    chk_state("borrow", 12'h099, 1'b1, 1'b0);
    chk("borrow_hex", 32'(hex), 32'(hex_exp(12'h099)));

    // Async reset while tick is high, then restart timing
    up_dn = 1'b1;
    do_load(12'h122);
    cyc(4);
    chk_state("pre_rst", 12'h123, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 12'h000, 1'b0, 1'b0);
    chk("async_rst_hex", 32'(hex), 32'(hex_exp(12'h000)));
    #2;
    rst_n = 1'b1;
    cyc(3);
    chk_state("post_rst3", 12'h000, 1'b0, 1'b0);
    cyc(1);
    chk_state("post_rst4", 12'h001, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
